// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolution slice: FSM encoding and
// default widths.
package bp_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } br_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves conditional branches in EX against the ID-stage prediction,
// issuing redirect/flush, predictor updates and hit/miss statistics.
module branch_resolve
    import bp_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              id_valid,
    input  logic              id_beq,
    input  logic              id_pred_taken,
    input  logic [ADDR_W-1:0] id_pc_plus4,
    input  logic [ADDR_W-1:0] id_target,
    input  logic              ex_equal,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic              upd_valid,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mis_cnt
);

    br_state_e         state;
    br_state_e         state_nxt;
    logic              ex_vld;
    logic              ex_pred;
    logic [ADDR_W-1:0] ex_pc4;
    logic [ADDR_W-1:0] ex_tgt;
    logic              resolve;
    logic              mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        resolve     = ex_vld & ~stall;
        mispredict  = resolve & (ex_equal != ex_pred);
        upd_valid   = resolve;
        upd_taken   = resolve & ex_equal;
        redirect    = mispredict;
        flush       = mispredict;
        redirect_pc = ex_equal ? ex_tgt : ex_pc4;
        state_nxt   = state;
        case (state)
            RUN:     if (mispredict) state_nxt = RECOVER;
            RECOVER: if (!stall)     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // A branch sitting in ID while EX mispredicts is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld  <= 1'b0;
            ex_pred <= 1'b0;
            ex_pc4  <= '0;
            ex_tgt  <= '0;
        end else if (!stall) begin
            ex_vld  <= id_valid & id_beq & (state == RUN) & ~mispredict;
            ex_pred <= id_pred_taken;
            ex_pc4  <= id_pc_plus4;
            ex_tgt  <= id_target;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve),
        .value (br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mis_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .value (mis_cnt)
    );

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (4-bit counters).
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic        id_beq;
    logic        id_pred_taken;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_target;
    logic        ex_equal;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        upd_valid;
    logic        upd_taken;
    logic [3:0]  br_cnt;
    logic [3:0]  mis_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    branch_resolve #(.ADDR_W(32), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .id_valid      (id_valid),
        .id_beq        (id_beq),
        .id_pred_taken (id_pred_taken),
        .id_pc_plus4   (id_pc_plus4),
        .id_target     (id_target),
        .ex_equal      (ex_equal),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .upd_valid     (upd_valid),
        .upd_taken     (upd_taken),
        .br_cnt        (br_cnt),
        .mis_cnt       (mis_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a branch in ID for one edge, then clear ID.
    task automatic issue(input logic pred, input logic [31:0] pc4, input logic [31:0] tgt);
        id_valid      = 1'b1;
        id_beq        = 1'b1;
        id_pred_taken = pred;
        id_pc_plus4   = pc4;
        id_target     = tgt;
        step();
        id_valid      = 1'b0;
        id_beq        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        total_cnt++; if (br_cnt !== 4'd0) $display("FAIL reset_br_cnt got=%0d exp=0", br_cnt); else pass_cnt++;
        total_cnt++; if (mis_cnt !== 4'd0) $display("FAIL reset_mis_cnt got=%0d exp=0", mis_cnt); else pass_cnt++;
        total_cnt++; if (redirect !== 1'b0) $display("FAIL reset_redirect got=%b exp=0", redirect); else pass_cnt++;
        total_cnt++; if (flush !== 1'b0) $display("FAIL reset_flush got=%b exp=0", flush); else pass_cnt++;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); else pass_cnt++;
    endtask

    task automatic test_correct();
        issue(1'b1, 32'h08, 32'h40);
        ex_equal = 1'b1;
        #1;
        total_cnt++; if (upd_valid !== 1'b1) $display("FAIL hit_upd_valid got=%b exp=1", upd_valid); else pass_cnt++;
        total_cnt++; if (upd_taken !== 1'b1) $display("FAIL hit_upd_taken got=%b exp=1", upd_taken); else pass_cnt++;
        total_cnt++; if (redirect !== 1'b0) $display("FAIL hit_redirect got=%b exp=0", redirect); else pass_cnt++;
        total_cnt++; if (flush !== 1'b0) $display("FAIL hit_flush got=%b exp=0", flush); else pass_cnt++;
        total_cnt++; if (br_cnt !== 4'd0) $display("FAIL hit_br_cnt_before got=%0d exp=0", br_cnt); else pass_cnt++;
        step();
        total_cnt++; if (br_cnt !== 4'd1) $display("FAIL hit_br_cnt_after got=%0d exp=1", br_cnt); else pass_cnt++;
        total_cnt++; if (mis_cnt !== 4'd0) $display("FAIL hit_mis_cnt got=%0d exp=0", mis_cnt); else pass_cnt++;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL hit_single_update got=%b exp=0", upd_valid); else pass_cnt++;
    endtask

    task automatic test_mispredict();
        issue(1'b1, 32'h14, 32'h100);
        ex_equal = 1'b0;
        #1;
        total_cnt++; if (redirect !== 1'b1) $display("FAIL miss_redirect got=%b exp=1", redirect); else pass_cnt++;
        total_cnt++; if (redirect_pc !== 32'h14) $display("FAIL miss_redirect_pc got=%h exp=00000014", redirect_pc); else pass_cnt++;
        total_cnt++; if (flush !== 1'b1) $display("FAIL miss_flush got=%b exp=1", flush); else pass_cnt++;
        total_cnt++; if (upd_taken !== 1'b0) $display("FAIL miss_upd_taken got=%b exp=0", upd_taken); else pass_cnt++;
        // wrong-path branch held in ID across the mispredict and the recovery cycle
        id_valid = 1'b1; id_beq = 1'b1; id_pred_taken = 1'b1;
        step();
        total_cnt++; if (mis_cnt !== 4'd1) $display("FAIL miss_mis_cnt got=%0d exp=1", mis_cnt); else pass_cnt++;
        total_cnt++; if (br_cnt !== 4'd2) $display("FAIL miss_br_cnt got=%0d exp=2", br_cnt); else pass_cnt++;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL miss_id_discard got=%b exp=0", upd_valid); else pass_cnt++;
        step();
        id_valid = 1'b0; id_beq = 1'b0;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL recover_no_capture got=%b exp=0", upd_valid); else pass_cnt++;
        step();
        total_cnt++; if (br_cnt !== 4'd2) $display("FAIL recover_br_cnt got=%0d exp=2", br_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 32'h30, 32'h80);
        id_valid = 1'b1; id_beq = 1'b1; id_pred_taken = 1'b0;
        id_pc_plus4 = 32'h84; id_target = 32'h200;
        ex_equal = 1'b1;
        #1;
        total_cnt++; if (redirect !== 1'b1) $display("FAIL b2b_redirect got=%b exp=1", redirect); else pass_cnt++;
        total_cnt++; if (redirect_pc !== 32'h80) $display("FAIL b2b_redirect_pc got=%h exp=00000080", redirect_pc); else pass_cnt++;
        step();
        id_valid = 1'b0; id_beq = 1'b0;
        #1;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL b2b_second_dropped got=%b exp=0", upd_valid); else pass_cnt++;
        total_cnt++; if (br_cnt !== 4'd3) $display("FAIL b2b_br_cnt got=%0d exp=3", br_cnt); else pass_cnt++;
        step();
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL b2b_no_late_update got=%b exp=0", upd_valid); else pass_cnt++;
        total_cnt++; if ((br_cnt !== 4'd3) || (mis_cnt !== 4'd2)) $display("FAIL b2b_counts got=%0d/%0d exp=3/2", br_cnt, mis_cnt); else pass_cnt++;
    endtask

    task automatic test_stall();
        int pulses = 0;
        issue(1'b0, 32'h50, 32'h60);
        stall    = 1'b1;
        ex_equal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if ({redirect, flush, upd_valid} !== 3'b000) $display("FAIL stall_quiet cyc=%0d got=%b exp=000", i, {redirect, flush, upd_valid}); else pass_cnt++;
            step();
        end
        total_cnt++; if (br_cnt !== 4'd3) $display("FAIL stall_br_hold got=%0d exp=3", br_cnt); else pass_cnt++;
        stall = 1'b0;
        #1;
        total_cnt++; if (redirect !== 1'b1) $display("FAIL stall_release_redirect got=%b exp=1", redirect); else pass_cnt++;
        total_cnt++; if (redirect_pc !== 32'h60) $display("FAIL stall_release_pc got=%h exp=00000060", redirect_pc); else pass_cnt++;
        if (redirect === 1'b1) pulses++;
        step();
        if (redirect === 1'b1) pulses++;
        total_cnt++; if (pulses !== 1) $display("FAIL stall_single_pulse got=%0d exp=1", pulses); else pass_cnt++;
        total_cnt++; if ((br_cnt !== 4'd4) || (mis_cnt !== 4'd3)) $display("FAIL stall_counts got=%0d/%0d exp=4/3", br_cnt, mis_cnt); else pass_cnt++;
        step();
    endtask

    task automatic test_non_branch();
        id_valid = 1'b1; id_beq = 1'b0;
        step();
        id_valid = 1'b0;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL nonbranch_upd got=%b exp=0", upd_valid); else pass_cnt++;
        id_beq = 1'b1;
        step();
        id_beq = 1'b0;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL invalid_upd got=%b exp=0", upd_valid); else pass_cnt++;
        step();
        total_cnt++; if (br_cnt !== 4'd4) $display("FAIL nonbranch_br_cnt got=%0d exp=4", br_cnt); else pass_cnt++;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 32'h10, 32'h20);
            ex_equal = 1'b0;
            step();
            step();
            if (i == 13) begin
                total_cnt++; if ((br_cnt !== 4'd14) || (mis_cnt !== 4'd14)) $display("FAIL sat_mid got=%0d/%0d exp=14/14", br_cnt, mis_cnt); else pass_cnt++;
            end
        end
        total_cnt++; if ((br_cnt !== 4'd15) || (mis_cnt !== 4'd15)) $display("FAIL sat_top got=%0d/%0d exp=15/15", br_cnt, mis_cnt); else pass_cnt++;
        issue(1'b1, 32'h10, 32'h20);
        step();
        step();
        total_cnt++; if ((br_cnt !== 4'd15) || (mis_cnt !== 4'd15)) $display("FAIL sat_hold got=%0d/%0d exp=15/15", br_cnt, mis_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_recover();
        // reset while a mispredicting branch is stalled in EX
        issue(1'b1, 32'h44, 32'h48);
        ex_equal = 1'b0;
        stall    = 1'b1;
        rst      = 1'b1;
        step();
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        total_cnt++; if ({upd_valid, redirect} !== 2'b00) $display("FAIL rst_stall_quiet got=%b exp=00", {upd_valid, redirect}); else pass_cnt++;
        total_cnt++; if ((br_cnt !== 4'd0) || (mis_cnt !== 4'd0)) $display("FAIL rst_stall_counts got=%0d/%0d exp=0/0", br_cnt, mis_cnt); else pass_cnt++;
        // reset while in RECOVER
        issue(1'b1, 32'h44, 32'h48);
        step();
        stall = 1'b1;
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        total_cnt++; if (upd_valid !== 1'b0) $display("FAIL rst_recover_upd got=%b exp=0", upd_valid); else pass_cnt++;
        total_cnt++; if ((br_cnt !== 4'd0) || (mis_cnt !== 4'd0)) $display("FAIL rst_recover_counts got=%0d/%0d exp=0/0", br_cnt, mis_cnt); else pass_cnt++;
        issue(1'b0, 32'h70, 32'h90);
        ex_equal = 1'b0;
        #1;
        total_cnt++; if (upd_valid !== 1'b1) $display("FAIL rst_recover_run got=%b exp=1", upd_valid); else pass_cnt++;
        step();
        total_cnt++; if (br_cnt !== 4'd1) $display("FAIL rst_recover_br_cnt got=%0d exp=1", br_cnt); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; id_valid = 1'b0; id_beq = 1'b0;
        id_pred_taken = 1'b0; id_pc_plus4 = '0; id_target = '0; ex_equal = 1'b0;
        test_reset();
        test_correct();
        test_mispredict();
        test_back_to_back();
        test_stall();
        test_non_branch();
        test_saturation();
        test_reset_recover();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
